data_memory_responder: RTL and testbench
========================================

// Module: data_memory_responder
// PURPOSE
//  Memory-side responder for the CPU's MEM-stage load/store port.
//  Byte-addressable data memory with configurable access latency.
//  Stalls the pipeline through BUSYWAIT, the same signal that freezes IF_ID/ID_EX.
//  Performs RV32I load sign/zero extension and store byte/half/word masking from FUNCT3.
// PARAMETERS
//  ADDR_BITS  10  byte-address bits decoded; memory is 2**ADDR_BITS bytes
//  LATENCY    4   ACCESS-state cycles per request (>=1)
// PORTS
//  CLK         in   1   clock, posedge
//  RESET       in   1   asynchronous, active-low reset
//  MEM_READ    in   1   load request, held by CPU until BUSYWAIT falls
//  MEM_WRITE   in   1   store request, held by CPU until BUSYWAIT falls
//  ADDRESS     in   32  byte address (ALU result)
//  WRITE_DATA  in   32  store data (rs2)
//  FUNCT3      in   3   access width/sign
//  READ_DATA   out  32  extended load result
//  BUSYWAIT    out  1   high = CPU must stall
// BEHAVIOUR
//  Reset (RESET=0, async): state=IDLE, BUSYWAIT=0, READ_DATA=0, latched request cleared.
//   Memory array not cleared.
//  FSM states IDLE, ACCESS, DONE:
//   IDLE: request = MEM_READ|MEM_WRITE.
//     BUSYWAIT = request, combinational and in the same cycle.
//     On posedge with request: latch ADDRESS/WRITE_DATA/FUNCT3/type, cnt=LATENCY-1, go ACCESS.
//   ACCESS: BUSYWAIT=1; cnt decrements each edge.
//     At edge with cnt==0: commit store to array or register load into READ_DATA; go DONE.
//   DONE: BUSYWAIT=0 for exactly one cycle; READ_DATA stable; the CPU advances at this edge.
//     Request inputs are ignored (they belong to the retiring access). Next edge -> IDLE.
//  Latency: request seen in IDLE cycle 0 -> BUSYWAIT high cycles 0..LATENCY, low in cycle LATENCY+1.
//  Back-to-back requests: a new request is recognised in the IDLE cycle after DONE.
//  Input changes during ACCESS do not affect the in-flight access (latched copy used).
//  Loads by FUNCT3:
//    000 LB: sign-extend byte
//    001 LH: sign-extend half
//    010 LW: word
//    100 LBU: zero-extend byte
//    101 LHU: zero-extend half
//    other: treated as LW
//  Stores by FUNCT3: 000 SB (byte), 001 SH (half), 010 SW (word), other: treated as SW.
//    Only addressed bytes are modified.
//  Little-endian: byte at ADDRESS holds data[7:0].
//  Alignment: half uses ADDRESS with bit0 forced 0; word uses ADDRESS with [1:0] forced 0.
//    No misalignment trap.
//  Address wrap: only ADDRESS[ADDR_BITS-1:0] decoded; upper bits ignored.
//  MEM_READ and MEM_WRITE both high: treated as store; READ_DATA keeps its previous value.
//  READ_DATA changes only at a load's commit edge or reset; it holds across stores and idle.
//  Reset mid-ACCESS: pending store is NOT committed; FSM returns to IDLE immediately.
// TESTING
//  1. SW 0xDEADBEEF @0x10 (LATENCY=4) -> BUSYWAIT high 5 cycles, low 1; LW @0x10 returns 0xDEADBEEF.
//  2. SB 0x80 @0x13, then LB @0x13 -> 0xFFFFFF80; LBU @0x13 -> 0x00000080; LW @0x10 -> 0x80ADBEEF.
//  3. SH 0x8001 @0x22; LH @0x23 (aligned down) -> 0xFFFF8001; LHU @0x22 -> 0x00008001.
//  4. SW 0x12345678 @0x400 (ADDR_BITS=10) -> LW @0x000 returns 0x12345678 (wrap).
//  5. Store in flight, RESET=0 at ACCESS cnt==1 -> BUSYWAIT=0 and READ_DATA=0 immediately;
//     later LW shows old word.
//  6. Request held through DONE -> exactly one access;
//     a new request in the following IDLE cycle asserts BUSYWAIT in that same cycle.

Source files
------------

// File: rtl/data_memory_responder_if.sv
// data_memory_responder_if: MEM-stage load/store port between CPU (master) and data memory (slave).
interface data_memory_responder_if;
   logic        mem_read;
   logic        mem_write;
   logic [31:0] address;
   logic [31:0] write_data;
   logic [2:0]  funct3;
   logic [31:0] read_data;
   logic        busywait;
   modport master (output mem_read, mem_write, address, write_data, funct3, input read_data, busywait);
   modport slave (input mem_read, mem_write, address, write_data, funct3, output read_data, busywait);
endinterface

// File: rtl/data_memory_responder.sv
// data_memory_responder: byte-addressable data memory with fixed access latency and RV32I load/store sizing.
module data_memory_responder #(
   parameter int ADDR_BITS = 10,
   parameter int LATENCY   = 4
) (
   input  logic                    clk,
   input  logic                    rst_n,
   data_memory_responder_if.slave  bus
);
   localparam int CW = LATENCY > 1 ? $clog2(LATENCY) : 1;
   typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;
   state_t               state_q, state_d;
   logic [CW-1:0]        cnt_q, cnt_d;
   logic [ADDR_BITS-1:0] addr_q, addr_d;
   logic [31:0]          wdata_q, wdata_d, rdata_q, rdata_d;
   logic [2:0]           f3_q, f3_d;
   logic                 wr_q, wr_d;
   logic [7:0]           mem [2**ADDR_BITS];
   logic                 req, commit;
   logic [31:0]          word, lanes, ld;
   logic [15:0]          h;
   logic [7:0]           b;
   logic [3:0]           be;
   logic                 unused_addr_hi;
   assign unused_addr_hi = ^bus.address[31:ADDR_BITS];
   assign bus.read_data = rdata_q;
   always_comb begin
      req = bus.mem_read | bus.mem_write;
      commit = state_q == ACCESS && cnt_q == '0;
      bus.busywait = rst_n & (state_q == ACCESS | (state_q == IDLE & req));
      word = {mem[{addr_q[ADDR_BITS-1:2], 2'd3}], mem[{addr_q[ADDR_BITS-1:2], 2'd2}],
              mem[{addr_q[ADDR_BITS-1:2], 2'd1}], mem[{addr_q[ADDR_BITS-1:2], 2'd0}]};
      b = word[{addr_q[1:0], 3'b000} +: 8];
      h = addr_q[1] ? word[31:16] : word[15:0];
      ld = f3_q == 3'b000 ? {{24{b[7]}}, b} :
           f3_q == 3'b001 ? {{16{h[15]}}, h} :
           f3_q == 3'b100 ? {24'b0, b} :
           f3_q == 3'b101 ? {16'b0, h} : word;
      be = f3_q == 3'b000 ? 4'b0001 << addr_q[1:0] :
           f3_q == 3'b001 ? (addr_q[1] ? 4'b1100 : 4'b0011) : 4'b1111;
      lanes = f3_q == 3'b000 ? {4{wdata_q[7:0]}} :
              f3_q == 3'b001 ? {2{wdata_q[15:0]}} : wdata_q;
      state_d = state_q == IDLE ? (req ? ACCESS : IDLE) :
                state_q == ACCESS ? (commit ? DONE : ACCESS) : IDLE;
      cnt_d = state_q == IDLE ? CW'(LATENCY - 1) : cnt_q - 1'b1;
      addr_d = addr_q;
      wdata_d = wdata_q;
      f3_d = f3_q;
      wr_d = wr_q;
      if (state_q == IDLE && req) begin
         addr_d = bus.address[ADDR_BITS-1:0];
         wdata_d = bus.write_data;
         f3_d = bus.funct3;
         wr_d = bus.mem_write;
      end
      rdata_d = commit && !wr_q ? ld : rdata_q;
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         cnt_q <= '0;
         addr_q <= '0;
         wdata_q <= '0;
         f3_q <= '0;
         wr_q <= 1'b0;
         rdata_q <= '0;
      end else begin
         state_q <= state_d;
         cnt_q <= cnt_d;
         addr_q <= addr_d;
         wdata_q <= wdata_d;
         f3_q <= f3_d;
         wr_q <= wr_d;
         rdata_q <= rdata_d;
      end
   end
   always_ff @(posedge clk) begin
      if (commit && wr_q)
         for (int i = 0; i < 4; i++)
            if (be[i]) mem[{addr_q[ADDR_BITS-1:2], 2'(i)}] <= lanes[8*i +: 8];
   end
endmodule

// File: tb/tb_data_memory_responder.sv
// tb_data_memory_responder: directed load/store sequence with hand-computed expectations.
module tb_data_memory_responder;
   logic clk;
   logic rst_n;
   int   n_chk = 0;
   int   n_err = 0;
   data_memory_responder_if bus ();
   data_memory_responder #(.ADDR_BITS(10), .LATENCY(4)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.slave)
   );
   initial clk = 1'b0;
   always #5 clk = ~clk;
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask
   task automatic drive(input logic rd, input logic wr, input logic [31:0] a, input logic [31:0] d, input logic [2:0] f);
      bus.mem_read = rd;
      bus.mem_write = wr;
      bus.address = a;
      bus.write_data = d;
      bus.funct3 = f;
   endtask
   task automatic access(input string tag, input logic rd, input logic wr, input logic [31:0] a, input logic [31:0] d, input logic [2:0] f);
      int n;
      @(negedge clk);
      drive(rd, wr, a, d, f);
      #1;
      chk({tag, "_busy0"}, {31'b0, bus.busywait}, 32'd1);
      n = 0;
      while (bus.busywait && n < 20) begin
         @(posedge clk);
         #1;
         n++;
      end
      chk({tag, "_lat"}, n, 32'd5);
      bus.mem_read = 1'b0;
      bus.mem_write = 1'b0;
      @(posedge clk);
      #1;
   endtask
   initial begin
      int n;
      rst_n = 1'b0;
      drive(1'b0, 1'b0, 32'h0, 32'h0, 3'b000);
      repeat (2) @(negedge clk);
      chk("rst_busy", {31'b0, bus.busywait}, 32'd0);
      chk("rst_rdata", bus.read_data, 32'h0);
      rst_n = 1'b1;
      access("sw1", 1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 3'b010);
      access("lw1", 1'b1, 1'b0, 32'h10, 32'h0, 3'b010);
      chk("lw1_data", bus.read_data, 32'hDEADBEEF);
      access("sb", 1'b0, 1'b1, 32'h13, 32'hAAAAAA80, 3'b000);
      chk("hold_after_store", bus.read_data, 32'hDEADBEEF);
      access("lb", 1'b1, 1'b0, 32'h13, 32'h0, 3'b000);
      chk("lb_data", bus.read_data, 32'hFFFFFF80);
      access("lbu", 1'b1, 1'b0, 32'h13, 32'h0, 3'b100);
      chk("lbu_data", bus.read_data, 32'h00000080);
      access("lw2", 1'b1, 1'b0, 32'h10, 32'h0, 3'b010);
      chk("lw2_data", bus.read_data, 32'h80ADBEEF);
      access("sh", 1'b0, 1'b1, 32'h22, 32'h55558001, 3'b001);
      access("lh", 1'b1, 1'b0, 32'h23, 32'h0, 3'b001);
      chk("lh_data", bus.read_data, 32'hFFFF8001);
      access("lhu", 1'b1, 1'b0, 32'h22, 32'h0, 3'b101);
      chk("lhu_data", bus.read_data, 32'h00008001);
      access("sw_wrap", 1'b0, 1'b1, 32'h400, 32'h12345678, 3'b010);
      access("lw_wrap", 1'b1, 1'b0, 32'h0, 32'h0, 3'b010);
      chk("wrap_data", bus.read_data, 32'h12345678);
      access("sw_f3x", 1'b0, 1'b1, 32'h30, 32'hA5A5A5A5, 3'b011);
      access("lw_f3x", 1'b1, 1'b0, 32'h30, 32'h0, 3'b111);
      chk("f3x_data", bus.read_data, 32'hA5A5A5A5);
      access("both", 1'b1, 1'b1, 32'h34, 32'h0BADF00D, 3'b010);
      chk("both_hold", bus.read_data, 32'hA5A5A5A5);
      access("lw_both", 1'b1, 1'b0, 32'h34, 32'h0, 3'b010);
      chk("both_data", bus.read_data, 32'h0BADF00D);
      access("sw_old", 1'b0, 1'b1, 32'h40, 32'h11223344, 3'b010);
      access("lw_old", 1'b1, 1'b0, 32'h40, 32'h0, 3'b010);
      chk("old_data", bus.read_data, 32'h11223344);
      @(negedge clk);
      drive(1'b0, 1'b1, 32'h40, 32'hCAFEBABE, 3'b010);
      repeat (3) @(posedge clk);
      #1;
      chk("rstmid_busy_pre", {31'b0, bus.busywait}, 32'd1);
      rst_n = 1'b0;
      bus.mem_write = 1'b0;
      #1;
      chk("rstmid_busy", {31'b0, bus.busywait}, 32'd0);
      chk("rstmid_rdata", bus.read_data, 32'h0);
      @(negedge clk);
      rst_n = 1'b1;
      access("lw_after_rst", 1'b1, 1'b0, 32'h40, 32'h0, 3'b010);
      chk("no_commit", bus.read_data, 32'h11223344);
      @(negedge clk);
      drive(1'b1, 1'b0, 32'h10, 32'h0, 3'b010);
      n = 0;
      #1;
      while (bus.busywait && n < 20) begin
         @(posedge clk);
         #1;
         n++;
      end
      chk("held_lat", n, 32'd5);
      drive(1'b1, 1'b0, 32'h13, 32'h0, 3'b000);
      #1;
      chk("held_done_busy", {31'b0, bus.busywait}, 32'd0);
      chk("held_done_rdata", bus.read_data, 32'h80ADBEEF);
      @(posedge clk);
      #1;
      chk("next_idle_busy", {31'b0, bus.busywait}, 32'd1);
      chk("next_idle_rdata", bus.read_data, 32'h80ADBEEF);
      n = 0;
      while (bus.busywait && n < 20) begin
         @(posedge clk);
         #1;
         n++;
      end
      chk("next_lat", n, 32'd5);
      chk("next_data", bus.read_data, 32'hFFFFFF80);
      drive(1'b0, 1'b0, 32'h0, 32'h0, 3'b000);
      @(posedge clk);
      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end
   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end
endmodule
